// File: rtl/ice51_uart_pkg.sv
// Shared types and frame constants for the ice51 UART.
// The PARITY states only become reachable when ICE51_UART_PARITY_EN is defined.
package ice51_uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/ice51_uart_fifo.sv
// Synchronous show-ahead FIFO; the head reads as zero while empty.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module ice51_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot in the same cycle, so a full FIFO may still accept a push.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  assign o_data = o_empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ice51_uart.sv
// Full-duplex UART with a FIFO per direction and configurable bit period and width.
// Define ICE51_UART_PARITY_EN to add an even parity bit to every frame.
module ice51_uart
  import ice51_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_uart_rx,
  output logic                 o_uart_tx,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  output logic                 o_tx_busy,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  input  logic                 i_rx_ready,
  output logic                 o_rx_overrun,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_parity_err,
  input  logic                 i_clr_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t            tx_state;
  tx_state_t            tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_bit_done;
  logic                 tx_load;
  logic                 tx_level;
  logic                 tx_empty;
  logic                 tx_full;

  rx_state_t            rx_state;
  rx_state_t            rx_next;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_bit_done;
  logic                 rx_half_done;
  logic                 rx_push_req;
  logic                 rx_frame_bad;
  logic                 rx_parity_bad;
  logic                 rx_empty;
  logic                 rx_full;
  logic                 rx_overrun_set;

`ifdef ICE51_UART_PARITY_EN
  logic                 tx_par;
  logic                 rx_par;
`endif

  assign o_tx_ready = !tx_full;
  assign o_tx_busy  = (tx_state != TX_IDLE) || !tx_empty;

  ice51_uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_push  (i_tx_valid && o_tx_ready),
    .i_data  (i_tx_data),
    .i_pop   (tx_load),
    .o_data  (tx_head),
    .o_empty (tx_empty),
    .o_full  (tx_full)
  );

  assign tx_bit_done = (tx_cnt == BIT_END);

  always_ff @(posedge i_clk) begin
    if (!i_nrst) tx_state <= TX_IDLE;
    else         tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (!tx_empty) tx_next = TX_START;
      TX_START:  if (tx_bit_done) tx_next = TX_DATA;
      TX_DATA: begin
        if (tx_bit_done && (tx_bit_idx == LAST_BIT)) begin
`ifdef ICE51_UART_PARITY_EN
          tx_next = TX_PARITY;
`else
          tx_next = TX_STOP;
`endif
        end
      end
      TX_PARITY: if (tx_bit_done) tx_next = TX_STOP;
      TX_STOP:   if (tx_bit_done) tx_next = tx_empty ? TX_IDLE : TX_START;
      default:   tx_next = TX_IDLE;
    endcase
  end

  // STOP reloads straight into the next START so queued frames leave with no idle gap.
  always_comb begin
    tx_load  = 1'b0;
    tx_level = STOP_LVL;
    case (tx_state)
      TX_IDLE:   tx_load = !tx_empty;
      TX_START:  tx_level = START_LVL;
      TX_DATA:   tx_level = tx_shift[0];
`ifdef ICE51_UART_PARITY_EN
      TX_PARITY: tx_level = tx_par;
`endif
      TX_STOP:   tx_load = tx_bit_done && !tx_empty;
      default:   tx_level = STOP_LVL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      o_uart_tx  <= STOP_LVL;
      tx_cnt     <= '0;
      tx_bit_idx <= '0;
      tx_shift   <= '0;
    end else begin
      o_uart_tx <= tx_level;
      if (tx_load) begin
        tx_shift   <= tx_head;
        tx_cnt     <= '0;
        tx_bit_idx <= '0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_bit_done) begin
          tx_cnt <= '0;
          if (tx_state == TX_DATA) begin
            tx_shift   <= tx_shift >> 1;
            tx_bit_idx <= tx_bit_idx + 1'b1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

`ifdef ICE51_UART_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (!i_nrst)      tx_par <= 1'b0;
    else if (tx_load) tx_par <= ^tx_head;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      rx_meta <= STOP_LVL;
      rx_sync <= STOP_LVL;
    end else begin
      rx_meta <= i_uart_rx;
      rx_sync <= rx_meta;
    end
  end

  assign rx_bit_done  = (rx_cnt == BIT_END);
  assign rx_half_done = (rx_cnt == HALF_END);

  always_ff @(posedge i_clk) begin
    if (!i_nrst) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  // The half-bit wait in START aligns every later sample with the middle of its bit.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_sync == START_LVL) rx_next = RX_START;
      RX_START:  if (rx_half_done) rx_next = (rx_sync == START_LVL) ? RX_DATA : RX_IDLE;
      RX_DATA: begin
        if (rx_bit_done && (rx_bit_idx == LAST_BIT)) begin
`ifdef ICE51_UART_PARITY_EN
          rx_next = RX_PARITY;
`else
          rx_next = RX_STOP;
`endif
        end
      end
      RX_PARITY: if (rx_bit_done) rx_next = RX_STOP;
      RX_STOP:   if (rx_bit_done) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push_req   = 1'b0;
    rx_frame_bad  = 1'b0;
    rx_parity_bad = 1'b0;
    if ((rx_state == RX_STOP) && rx_bit_done) begin
      rx_frame_bad = (rx_sync != STOP_LVL);
`ifdef ICE51_UART_PARITY_EN
      rx_parity_bad = (rx_par != ^rx_shift);
`endif
      rx_push_req = !rx_frame_bad && !rx_parity_bad;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt     <= '0;
          rx_bit_idx <= '0;
        end
        RX_START: rx_cnt <= rx_half_done ? '0 : rx_cnt + 1'b1;
        default: begin
          if (rx_bit_done) begin
            rx_cnt <= '0;
            if (rx_state == RX_DATA) begin
              rx_shift   <= {rx_sync, rx_shift[DATA_BITS-1:1]};
              rx_bit_idx <= rx_bit_idx + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef ICE51_UART_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (!i_nrst)                                     rx_par <= 1'b0;
    else if ((rx_state == RX_PARITY) && rx_bit_done) rx_par <= rx_sync;
  end
`endif

  ice51_uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_push  (rx_push_req),
    .i_data  (rx_shift),
    .i_pop   (i_rx_ready),
    .o_data  (o_rx_data),
    .o_empty (rx_empty),
    .o_full  (rx_full)
  );

  assign o_rx_valid     = !rx_empty;
  assign rx_overrun_set = rx_push_req && rx_full && !i_rx_ready;

  // A new error event outranks a simultaneous clear so no event is ever lost.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      o_rx_overrun   <= 1'b0;
      o_rx_frame_err <= 1'b0;
    end else begin
      if (rx_overrun_set) o_rx_overrun <= 1'b1;
      else if (i_clr_err) o_rx_overrun <= 1'b0;
      if (rx_frame_bad)   o_rx_frame_err <= 1'b1;
      else if (i_clr_err) o_rx_frame_err <= 1'b0;
    end
  end

`ifdef ICE51_UART_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (!i_nrst)            o_rx_parity_err <= 1'b0;
    else if (rx_parity_bad) o_rx_parity_err <= 1'b1;
    else if (i_clr_err)     o_rx_parity_err <= 1'b0;
  end
`else
  assign o_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ice51_uart.sv
// Scoreboarded bench for ice51_uart at CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4.
// Parity scenarios are included when ICE51_UART_PARITY_EN is defined.
module tb_ice51_uart;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef ICE51_UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (2 + 8 + P) * CPB;

  logic       clk = 1'b0;
  logic       nrst;
  logic       uart_rx;
  logic       uart_tx;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       clr_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] tx_sb[$];
  logic [7:0] rx_sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ice51_uart #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_nrst          (nrst),
    .i_uart_rx       (uart_rx),
    .o_uart_tx       (uart_tx),
    .i_tx_valid      (tx_valid),
    .i_tx_data       (tx_data),
    .o_tx_ready      (tx_ready),
    .o_tx_busy       (tx_busy),
    .o_rx_valid      (rx_valid),
    .o_rx_data       (rx_data),
    .i_rx_ready      (rx_ready),
    .o_rx_overrun    (rx_overrun),
    .o_rx_frame_err  (rx_frame_err),
    .o_rx_parity_err (rx_parity_err),
    .i_clr_err       (clr_err)
  );

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Drives one serial frame into the receiver, starting at a negedge.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_lvl, input logic bad_par);
    logic pbit;
    pbit = (^data) ^ bad_par;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef ICE51_UART_PARITY_EN
    drive_bit(pbit);
`endif
    drive_bit(stop_lvl);
    uart_rx = 1'b1;
  endtask

  // Decodes one frame from the transmitter by mid-bit sampling.
  task automatic capture_tx(output logic [7:0] data, output logic par, output logic start_ok,
                            output logic stop, output int start_cyc, output logic timed_out);
    int guard;
    guard     = 0;
    timed_out = 1'b0;
    data      = '0;
    par       = 1'b0;
    start_ok  = 1'b0;
    stop      = 1'b0;
    start_cyc = 0;
    while (uart_tx !== 1'b0 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4000) begin
      timed_out = 1'b1;
    end else begin
      start_cyc = cyc;
      repeat (CPB / 2) @(negedge clk);
      start_ok = (uart_tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        data[i] = uart_tx;
      end
`ifdef ICE51_UART_PARITY_EN
      repeat (CPB) @(negedge clk);
      par = uart_tx;
`endif
      repeat (CPB) @(negedge clk);
      stop = uart_tx;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; uart_rx = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0; clr_err = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_uart_tx: got %b want 1", uart_tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_ready: got %b want 1", tx_ready); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_busy: got %b want 0", tx_busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++;
    if ({rx_overrun, rx_frame_err, rx_parity_err} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_err_flags: got %b want 000", {rx_overrun, rx_frame_err, rx_parity_err});
    end
    nrst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_tx_single();
    logic [7:0] d; logic par, sok, stp, to; int s, hs;
    tx_data = 8'hA5; tx_valid = 1'b1; tx_sb.push_back(8'hA5);
    @(posedge clk); #1;
    hs = cyc; tx_valid = 1'b0;
    capture_tx(d, par, sok, stp, s, to);
    checks++;
    if (to) begin
      errors++; $display("[TB] FAIL tx_single_timeout: no start bit seen");
    end else begin
      if (s !== hs + 2) begin errors++; $display("[TB] FAIL tx_single_latency: start at cycle %0d want %0d", s, hs + 2); end
      checks++; if (d !== tx_sb.pop_front()) begin errors++; $display("[TB] FAIL tx_single_data: got %h want a5", d); end
      checks++; if ({sok, stp} !== 2'b11) begin errors++; $display("[TB] FAIL tx_single_framing: start_ok/stop got %b want 11", {sok, stp}); end
      while (cyc < s + FRAME - 2) @(negedge clk);
      checks++; if (tx_busy !== 1'b1) begin errors++; $display("[TB] FAIL tx_single_busy_hold: got %b want 1", tx_busy); end
      @(negedge clk);
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL tx_single_busy_fall: got %b want 0", tx_busy); end
    end
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    int stall, sent;
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    stall = -1;
    sent  = 0;
    fork
      begin
        int guard;
        logic r;
        guard = 0;
        while (sent < 6 && guard < 3000) begin
          tx_valid = 1'b1; tx_data = bytes[sent];
          r = tx_ready;
          @(posedge clk);
          if (r) begin
            tx_sb.push_back(bytes[sent]);
            sent++;
          end else if (stall < 0) begin
            stall = sent;
          end
          @(negedge clk);
          guard++;
        end
        tx_valid = 1'b0;
      end
      begin
        logic [7:0] d; logic par, sok, stp, to; int s, prev;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
          capture_tx(d, par, sok, stp, s, to);
          checks++;
          if (to) begin
            errors++; $display("[TB] FAIL b2b_timeout: frame %0d not seen", k);
            break;
          end
          if (tx_sb.size() == 0) begin
            errors++; $display("[TB] FAIL b2b_data: frame %0d got %h with nothing queued", k, d);
          end else begin
            logic [7:0] exp;
            exp = tx_sb.pop_front();
            if (d !== exp) begin errors++; $display("[TB] FAIL b2b_data: frame %0d got %h want %h", k, d, exp); end
          end
          if (k > 0) begin
            checks++;
            if (s - prev !== FRAME) begin errors++; $display("[TB] FAIL b2b_gap: frame %0d spacing %0d want %0d", k, s - prev, FRAME); end
          end
          prev = s;
        end
        while (cyc < prev + FRAME - 2) @(negedge clk);
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy_hold: got %b want 1", tx_busy); end
        @(negedge clk);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_fall: got %b want 0", tx_busy); end
      end
    join
    checks++; if (stall !== DEPTH + 1) begin errors++; $display("[TB] FAIL b2b_ready_drop: stalled after %0d accepts want %0d", stall, DEPTH + 1); end
    checks++; if (sent !== 6) begin errors++; $display("[TB] FAIL b2b_all_accepted: got %0d want 6", sent); end
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_rx_single();
    int guard;
    rx_sb.push_back(8'h3C);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    guard = 0;
    while (rx_valid !== 1'b1 && guard < 4 * CPB) begin @(negedge clk); guard++; end
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL rx_single_valid: got %b want 1", rx_valid);
    end else begin
      logic [7:0] exp;
      exp = rx_sb.pop_front();
      checks++; if (rx_data !== exp) begin errors++; $display("[TB] FAIL rx_single_data: got %h want %h", rx_data, exp); end
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rx_single_pop: valid %b want 0", rx_valid); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("[TB] FAIL rx_single_no_err: frame_err %b want 0", rx_frame_err); end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] b [5];
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) rx_sb.push_back(b[i]);
      applyStimulus(b[i], 1'b1, 1'b0);
      if (i == DEPTH - 1) begin
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("[TB] FAIL rx_overrun_early: got %b want 0", rx_overrun); end
      end
    end
    repeat (CPB) @(negedge clk);
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("[TB] FAIL rx_overrun_set: got %b want 1", rx_overrun); end
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] exp;
      exp = rx_sb.pop_front();
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp) begin
        errors++; $display("[TB] FAIL rx_overrun_order: entry %0d valid %b data %h want 1/%h", i, rx_valid, rx_data, exp);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rx_overrun_drained: valid %b want 0", rx_valid); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("[TB] FAIL rx_overrun_clear: got %b want 0", rx_overrun); end
  endtask

  task automatic test_rx_errors();
    int guard;
    applyStimulus(8'h5A, 1'b0, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("[TB] FAIL rx_frame_err_set: got %b want 1", rx_frame_err); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rx_frame_err_nopush: valid %b want 0", rx_valid); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("[TB] FAIL rx_frame_err_clear: got %b want 0", rx_frame_err); end

    uart_rx = 1'b0;
    repeat (6) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if ({rx_valid, rx_frame_err, rx_overrun} !== 3'b000) begin
      errors++; $display("[TB] FAIL rx_glitch_ignored: valid/frame/overrun %b want 000", {rx_valid, rx_frame_err, rx_overrun});
    end
    rx_sb.push_back(8'h96);
    applyStimulus(8'h96, 1'b1, 1'b0);
    guard = 0;
    while (rx_valid !== 1'b1 && guard < 4 * CPB) begin @(negedge clk); guard++; end
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL rx_after_glitch_valid: got %b want 1", rx_valid);
    end else begin
      logic [7:0] exp;
      exp = rx_sb.pop_front();
      checks++; if (rx_data !== exp) begin errors++; $display("[TB] FAIL rx_after_glitch_data: got %h want %h", rx_data, exp); end
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("[TB] FAIL rx_parity_quiet: got %b want 0", rx_parity_err); end
  endtask

`ifdef ICE51_UART_PARITY_EN
  task automatic test_parity();
    logic [7:0] d; logic par, sok, stp, to; int s;
    tx_data = 8'h07; tx_valid = 1'b1; tx_sb.push_back(8'h07);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    capture_tx(d, par, sok, stp, s, to);
    checks++;
    if (to) begin
      errors++; $display("[TB] FAIL parity_tx_timeout: no start bit seen");
    end else begin
      if (d !== tx_sb.pop_front()) begin errors++; $display("[TB] FAIL parity_tx_data: got %h want 07", d); end
      checks++; if (par !== 1'b1) begin errors++; $display("[TB] FAIL parity_tx_bit: got %b want 1", par); end
    end
    repeat (2 * CPB) @(negedge clk);
    applyStimulus(8'h3C, 1'b1, 1'b1);
    repeat (CPB) @(negedge clk);
    checks++; if (rx_parity_err !== 1'b1) begin errors++; $display("[TB] FAIL parity_rx_err: got %b want 1", rx_parity_err); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL parity_rx_nopush: valid %b want 0", rx_valid); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("[TB] FAIL parity_rx_clear: got %b want 0", rx_parity_err); end
  endtask
`endif

  task automatic test_reset_midframe();
    tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("[TB] FAIL midframe_line_low: got %b want 0", uart_tx); end
    nrst = 1'b0;
    uart_rx = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({uart_tx, tx_busy, tx_ready} !== 3'b101) begin
      errors++; $display("[TB] FAIL midframe_reset_tx: tx/busy/ready %b want 101", {uart_tx, tx_busy, tx_ready});
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checks++;
    if ({uart_tx, rx_valid, rx_frame_err} !== 3'b100) begin
      errors++; $display("[TB] FAIL midframe_after: tx/rx_valid/frame_err %b want 100", {uart_tx, rx_valid, rx_frame_err});
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_single();
    test_rx_overrun();
    test_rx_errors();
`ifdef ICE51_UART_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
